// File: rtl/dmem_responder.sv
// dmem_responder: byte-lane data memory with a fixed-latency, flushable load pipeline.
// Build macro DMEM_MISALIGN_CHECK_EN: adds the mem_misalign output and drops misaligned
// half/word accesses; without it, misaligned addresses are force-aligned.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned LOAD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_store_en,
  input  logic [1:0]  mem_store_type,
  input  logic [31:0] mem_store_addr,
  input  logic [31:0] mem_store_value,
  input  logic        mem_load_en,
  input  logic [1:0]  mem_load_type,
  input  logic [31:0] mem_load_addr,
  input  logic        flush_en,
  output logic [31:0] mem_load_value,
  output logic        mem_load_valid
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic        mem_misalign
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ACC_BYTE = 2'b00,
    ACC_HALF = 2'b01,
    ACC_WORD = 2'b10,
    ACC_RSVD = 2'b11
  } acc_e;

  logic [31:0]             mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]        storeIdx;
  logic [IDX_W-1:0]        loadIdx;
  logic [3:0]              storeBe;
  logic [31:0]             storeData;
  logic                    storeMis;
  logic                    loadMis;
  logic                    storeLegal;
  logic                    loadLegal;
  logic                    storeFire;
  logic                    loadFire;
  logic [31:0]             mergedWord;
  logic [31:0]             loadResult;

  logic [LOAD_LATENCY-1:0] pipeValid_q;
  logic [LOAD_LATENCY-1:0] pipeValid_d;
  logic [31:0]             pipeData_q [LOAD_LATENCY];
  logic [31:0]             pipeData_d [LOAD_LATENCY];

  // The word index wraps modulo the depth, so the upper address bits are deliberately ignored.
  assign storeIdx = mem_store_addr[IDX_W+1:2];
  assign loadIdx  = mem_load_addr[IDX_W+1:2];

  logic unusedAddrBits;
  assign unusedAddrBits = ^{mem_store_addr[31:IDX_W+2], mem_load_addr[31:IDX_W+2]};

  // Requests seen while reset is high are discarded outright; reserved types never act.
  assign storeLegal = mem_store_en && (acc_e'(mem_store_type) != ACC_RSVD) && !rst;
  assign loadLegal  = mem_load_en  && (acc_e'(mem_load_type)  != ACC_RSVD) && !rst;

  // Turn a store into byte enables plus lane-replicated data; half lanes ignore addr[0].
  always_comb begin
    storeBe   = 4'b0000;
    storeData = 32'h0;
    storeMis  = 1'b0;
    case (acc_e'(mem_store_type))
      ACC_BYTE: begin
        storeBe   = 4'b0001 << mem_store_addr[1:0];
        storeData = {4{mem_store_value[7:0]}};
      end
      ACC_HALF: begin
        storeBe   = mem_store_addr[1] ? 4'b1100 : 4'b0011;
        storeData = {2{mem_store_value[15:0]}};
        storeMis  = mem_store_addr[0];
      end
      ACC_WORD: begin
        storeBe   = 4'b1111;
        storeData = mem_store_value;
        storeMis  = |mem_store_addr[1:0];
      end
      default: begin
        storeBe = 4'b0000;
      end
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_d;

  assign storeFire  = storeLegal && !storeMis;
  assign loadFire   = loadLegal && !loadMis && !flush_en;
  assign misalign_d = (storeLegal && storeMis) || (loadLegal && loadMis);

  // One-cycle registered report of any dropped misaligned access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign mem_misalign = misalign_q;
`else
  assign storeFire = storeLegal;
  assign loadFire  = loadLegal && !flush_en;

  logic unusedMisFlags;
  assign unusedMisFlags = storeMis ^ loadMis;
`endif

  // Read the addressed word with a same-cycle store merged in (write-first), then pick the lane.
  always_comb begin
    mergedWord = mem_q[loadIdx];
    for (int b = 0; b < 4; b++) begin
      if (storeFire && (storeIdx == loadIdx) && storeBe[b]) begin
        mergedWord[8*b +: 8] = storeData[8*b +: 8];
      end
    end
    loadMis    = 1'b0;
    loadResult = mergedWord;
    case (acc_e'(mem_load_type))
      ACC_BYTE: begin
        loadResult = {24'h0, mergedWord[{mem_load_addr[1:0], 3'b000} +: 8]};
      end
      ACC_HALF: begin
        loadResult = {16'h0, mergedWord[{mem_load_addr[1], 4'b0000} +: 16]};
        loadMis    = mem_load_addr[0];
      end
      ACC_WORD: begin
        loadResult = mergedWord;
        loadMis    = |mem_load_addr[1:0];
      end
      default: begin
        loadResult = 32'h0;
      end
    endcase
  end

  // Lane-masked array write; contents are never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (storeFire && storeBe[b]) begin
        mem_q[storeIdx][8*b +: 8] <= storeData[8*b +: 8];
      end
    end
  end

  // Next state of the load pipeline: a flush kills every in-flight entry as it advances.
  always_comb begin
    pipeValid_d    = '0;
    pipeValid_d[0] = loadFire;
    pipeData_d[0]  = loadFire ? loadResult : 32'h0;
    for (int i = 1; i < LOAD_LATENCY; i++) begin
      pipeValid_d[i] = pipeValid_q[i-1] && !flush_en;
      pipeData_d[i]  = pipeData_q[i-1];
    end
  end

  // Pipeline registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipeValid_q <= '0;
      for (int i = 0; i < LOAD_LATENCY; i++) begin
        pipeData_q[i] <= 32'h0;
      end
    end else begin
      pipeValid_q <= pipeValid_d;
      pipeData_q  <= pipeData_d;
    end
  end

  // A response being presented during a flush cycle is suppressed as well; data is zero when idle.
  assign mem_load_valid = pipeValid_q[LOAD_LATENCY-1] && !flush_en;
  assign mem_load_value = mem_load_valid ? pipeData_q[LOAD_LATENCY-1] : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against a byte-array model.
// Honours DMEM_MISALIGN_CHECK_EN the same way as the design.
module tb_dmem_responder;

  localparam int DEPTH  = 64;
  localparam int LAT    = 2;
  localparam int NBYTES = DEPTH * 4;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        mem_store_en;
  logic [1:0]  mem_store_type;
  logic [31:0] mem_store_addr;
  logic [31:0] mem_store_value;
  logic        mem_load_en;
  logic [1:0]  mem_load_type;
  logic [31:0] mem_load_addr;
  logic        flush_en;
  logic [31:0] mem_load_value;
  logic        mem_load_valid;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        mem_misalign;
  int          misCount;
`endif

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LOAD_LATENCY(LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_store_en   (mem_store_en),
    .mem_store_type (mem_store_type),
    .mem_store_addr (mem_store_addr),
    .mem_store_value(mem_store_value),
    .mem_load_en    (mem_load_en),
    .mem_load_type  (mem_load_type),
    .mem_load_addr  (mem_load_addr),
    .flush_en       (flush_en),
    .mem_load_value (mem_load_value),
    .mem_load_valid (mem_load_valid)
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    .mem_misalign   (mem_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] val;
  } resp_t;

  logic [7:0]  memModel [NBYTES];
  resp_t       pending[$];
  logic [31:0] seen[$];
  int          seenEdge[$];
  int          edgeNum;
  int          checks;
  int          errors;
  logic        expMis;
  int          loadEdge;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic se, input logic [1:0] st, input logic [31:0] sa,
                               input logic [31:0] sv, input logic le, input logic [1:0] lt,
                               input logic [31:0] la, input logic fl);
    mem_store_en    = se;
    mem_store_type  = st;
    mem_store_addr  = sa;
    mem_store_value = sv;
    mem_load_en     = le;
    mem_load_type   = lt;
    mem_load_addr   = la;
    flush_en        = fl;
  endtask

  function automatic int accessBytes(input logic [1:0] t);
    return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
  endfunction

  // Byte address of the first byte touched, after wrap-around and force-alignment.
  function automatic int baseAddr(input logic [1:0] t, input logic [31:0] a);
    int x;
    x = int'(a % 32'(NBYTES));
    if (t == 2'd1) x = x - (x % 2);
    if (t == 2'd2) x = x - (x % 4);
    return x;
  endfunction

  function automatic bit misaligned(input logic [1:0] t, input logic [31:0] a);
    return (t == 2'd1 && (a % 2) != 0) || (t == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic bit accessOk(input logic [1:0] t, input logic [31:0] a);
    return (t != 2'd3) && !(MIS_EN && misaligned(t, a));
  endfunction

  // Model of what happens at a rising edge: store first (write-first), then flush or accept a load.
  task automatic modelEdge();
    int          b;
    logic [31:0] tmp;
    logic [31:0] val;
    resp_t       r;
    edgeNum++;
    expMis = 1'b0;
    if (rst) begin
      pending.delete();
      return;
    end
    if (MIS_EN && ((mem_store_en && mem_store_type != 2'd3 && misaligned(mem_store_type, mem_store_addr)) ||
                   (mem_load_en && mem_load_type != 2'd3 && misaligned(mem_load_type, mem_load_addr))))
      expMis = 1'b1;
    if (mem_store_en && accessOk(mem_store_type, mem_store_addr)) begin
      b = baseAddr(mem_store_type, mem_store_addr);
      for (int i = 0; i < accessBytes(mem_store_type); i++) begin
        tmp = mem_store_value >> (8 * i);
        memModel[b + i] = tmp[7:0];
      end
    end
    if (flush_en) begin
      pending.delete();
    end else if (mem_load_en && accessOk(mem_load_type, mem_load_addr)) begin
      b   = baseAddr(mem_load_type, mem_load_addr);
      val = 32'h0;
      for (int i = 0; i < accessBytes(mem_load_type); i++)
        val = val | (32'(memModel[b + i]) << (8 * i));
      r.due = edgeNum + LAT - 1;
      r.val = val;
      pending.push_back(r);
    end
  endtask

  // Sample outputs mid-cycle with the current inputs applied, then let one edge pass.
  task automatic runCycle();
    logic        expV;
    logic [31:0] expD;
    @(negedge clk);
    expV = 1'b0;
    expD = 32'h0;
    if (pending.size() > 0 && pending[0].due == edgeNum) begin
      if (!flush_en && !rst) begin
        expV = 1'b1;
        expD = pending[0].val;
      end
      void'(pending.pop_front());
    end
    checkOutput("load_valid", 32'(mem_load_valid), 32'(expV));
    checkOutput("load_value", mem_load_value, expD);
`ifdef DMEM_MISALIGN_CHECK_EN
    checkOutput("misalign", 32'(mem_misalign), 32'(expMis));
    if (mem_misalign === 1'b1) misCount++;
`endif
    if (mem_load_valid === 1'b1) begin
      seen.push_back(mem_load_value);
      seenEdge.push_back(edgeNum);
    end
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
    repeat (n) runCycle();
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom % 4)
      0:       return $urandom;
      1:       return $urandom % (2 * NBYTES);
      default: return $urandom % 64;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    edgeNum = 0;
    expMis  = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    misCount = 0;
`endif
    for (int i = 0; i < NBYTES; i++) memModel[i] = 8'h00;
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
    #1;
    checkOutput("reset_valid", 32'(mem_load_valid), 32'd0);
    checkOutput("reset_value", mem_load_value, 32'd0);
    idle(2);
    rst = 1'b0;

    $display("[TB] clearing array");
    for (int w = 0; w < DEPTH; w++) begin
      applyStimulus(1'b1, 2'd2, 32'(w * 4), 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
      runCycle();
    end
    idle(1);

    $display("[TB] store word then load word");
    seen.delete(); seenEdge.delete();
    applyStimulus(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 2'd0, 32'h0, 1'b0);
    runCycle();
    idle(1);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 32'h10, 1'b0);
    runCycle();
    loadEdge = edgeNum;
    idle(4);
    checkOutput("basic_count", 32'(seen.size()), 32'd1);
    checkOutput("basic_value", seen.size() > 0 ? seen[0] : 32'hX, 32'hDEADBEEF);
    checkOutput("basic_latency", seenEdge.size() > 0 ? 32'(seenEdge[0] + 1 - loadEdge) : 32'hX, 32'(LAT));

    $display("[TB] byte merge");
    seen.delete(); seenEdge.delete();
    applyStimulus(1'b1, 2'd2, 32'h10, 32'h11223344, 1'b0, 2'd0, 32'h0, 1'b0);
    runCycle();
    applyStimulus(1'b1, 2'd0, 32'h13, 32'h000000AA, 1'b0, 2'd0, 32'h0, 1'b0);
    runCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 32'h10, 1'b0);
    runCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd1, 32'h12, 1'b0);
    runCycle();
    idle(4);
    checkOutput("merge_word", seen.size() > 0 ? seen[0] : 32'hX, 32'hAA223344);
    checkOutput("merge_half", seen.size() > 1 ? seen[1] : 32'hX, 32'h0000AA22);

    $display("[TB] back-to-back loads");
    seen.delete(); seenEdge.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'd2, 32'(i * 4), 32'(i + 1), 1'b0, 2'd0, 32'h0, 1'b0);
      runCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 32'(i * 4), 1'b0);
      runCycle();
    end
    idle(4);
    checkOutput("b2b_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("b2b_value", seen.size() > i ? seen[i] : 32'hX, 32'(i + 1));
    checkOutput("b2b_spacing", seenEdge.size() == 4 ? 32'(seenEdge[3] - seenEdge[0]) : 32'hX, 32'd3);

    $display("[TB] write-first and post-accept store");
    seen.delete(); seenEdge.delete();
    applyStimulus(1'b1, 2'd2, 32'h20, 32'd5, 1'b0, 2'd0, 32'h0, 1'b0);
    runCycle();
    applyStimulus(1'b1, 2'd2, 32'h20, 32'd9, 1'b1, 2'd2, 32'h20, 1'b0);
    runCycle();
    applyStimulus(1'b1, 2'd2, 32'h20, 32'd7, 1'b0, 2'd0, 32'h0, 1'b0);
    runCycle();
    idle(3);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 32'h20, 1'b0);
    runCycle();
    idle(3);
    checkOutput("wfirst_value", seen.size() > 0 ? seen[0] : 32'hX, 32'd9);
    checkOutput("later_store", seen.size() > 1 ? seen[1] : 32'hX, 32'd7);

    $display("[TB] flush");
    seen.delete(); seenEdge.delete();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 32'h0, 1'b0);
    runCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 32'h4, 1'b0);
    runCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b1);
    runCycle();
    idle(4);
    checkOutput("flush_count", 32'(seen.size()), 32'd0);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 32'h8, 1'b0);
    runCycle();
    idle(3);
    checkOutput("post_flush", seen.size() > 0 ? seen[0] : 32'hX, 32'd3);

`ifdef DMEM_MISALIGN_CHECK_EN
    $display("[TB] misaligned word load");
    seen.delete(); seenEdge.delete();
    misCount = 0;
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 32'h6, 1'b0);
    runCycle();
    idle(3);
    checkOutput("misalign_pulses", 32'(misCount), 32'd1);
    checkOutput("misalign_noresp", 32'(seen.size()), 32'd0);
`endif

    $display("[TB] reset during load");
    seen.delete(); seenEdge.delete();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 32'h10, 1'b0);
    runCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("pre_reset_valid", 32'(mem_load_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_valid", 32'(mem_load_valid), 32'd0);
    checkOutput("async_reset_value", mem_load_value, 32'd0);
    pending.delete();
    applyStimulus(1'b1, 2'd2, 32'h10, 32'h55555555, 1'b1, 2'd2, 32'h10, 1'b0);
    runCycle();
    runCycle();
    rst = 1'b0;
    idle(4);
    checkOutput("no_stale_resp", 32'(seen.size()), 32'd0);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 32'h10, 1'b0);
    runCycle();
    idle(3);
    checkOutput("reset_store_dropped", seen.size() > 0 ? seen[0] : 32'hX, 32'hAA223344);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 2) == 1, 2'($urandom % 4), randAddr(), $urandom,
                    ($urandom % 2) == 1, 2'($urandom % 4), randAddr(), ($urandom % 16) == 0);
      runCycle();
    end
    idle(LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, data-array depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LOAD_LATENCY, default 2, cycles from load acceptance to response (legal range 1..8).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_store_en  input  1  store request, one per cycle.
REQ-006 SHALL have port mem_store_type  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 SHALL have ports mem_store_addr and mem_store_value, each input 32, holding the byte address and the store data (LSB-aligned).
REQ-008 SHALL have port mem_load_en  input  1  load request, one per cycle.
REQ-009 SHALL have ports mem_load_type input 2 (same encoding as stores) and mem_load_addr input 32 (byte address).
REQ-010 SHALL have port flush_en  input  1  kills all in-flight loads.
REQ-011 SHALL have port mem_load_value  output  32  load data, zero-extended.
REQ-012 SHALL have port mem_load_valid  output  1  one-cycle pulse per surviving load.

Function
REQ-013 SHALL index the array with word address addr[log2(DEPTH_WORDS)+1:2], wrapping modulo DEPTH_WORDS.
REQ-014 SHALL, on a store, write only the addressed lanes: byte writes lane addr[1:0], half writes lanes {addr[1],0} and +1, and word writes all four lanes. Little-endian.
REQ-015 SHALL ignore a store or load with type 11: no write, no response.
REQ-016 SHALL accept a load every cycle and read the array at the acceptance edge. Through the pipeline, the result SHALL be presented with mem_load_valid exactly LOAD_LATENCY cycles later, in order.
REQ-017 SHALL extract the byte or half lane selected by addr[1:0] and place it at bits [7:0] or [15:0], zero-filling the upper bits.
REQ-018 SHALL give write-first results when a load and a store overlap bytes in the same cycle: the load returns the newly stored bytes.
REQ-019 SHALL NOT change the result of an already-accepted load when a later store hits the same address.
REQ-020 SHALL, when flush_en is high, clear all in-flight load valids. A load presented in the same cycle as flush_en SHALL also be dropped.
REQ-021 SHALL drive mem_load_value to 0 in any cycle mem_load_valid is low.
REQ-022 SHALL NOT apply backpressure; there is no ready signal, and requests are always accepted.

Reset
REQ-023 SHALL, on rst assertion, immediately clear all pipeline valids and drive mem_load_valid=0 and mem_load_value=0, without waiting for clk.
REQ-024 SHALL NOT reset array contents; simulation initialises the array to zero.
REQ-025 SHALL discard any load or store presented while rst is high; loads in flight when reset asserts never respond.

Configuration
REQ-026 SHALL support the macro DMEM_MISALIGN_CHECK_EN.
- When defined: adds output mem_misalign (1 bit), a registered pulse one cycle after a half access with addr[0]=1 or a word access with addr[1:0]!=00. The access is dropped (no write, no load response). Reset value is 0.
- When undefined: no such port exists, and misaligned addresses are force-aligned by ignoring the offending low bits.

Verification
REQ-027 SHALL pass: store word 0xDEADBEEF @0x10, then load word @0x10 two cycles later -> valid pulse 2 cycles after acceptance, value 0xDEADBEEF.
REQ-028 SHALL pass: store byte 0xAA @0x13 over 0x11223344 @0x10, load word @0x10 -> 0xAA223344; load half @0x12 -> 0x0000AA22.
REQ-029 SHALL pass: loads on 4 consecutive cycles @0x0,0x4,0x8,0xC preloaded with 1,2,3,4 -> 4 consecutive valid pulses returning 1,2,3,4.
REQ-030 SHALL pass: load @0x20 (holding 5) with a same-cycle store word 9 @0x20 -> 9. A store of 7 @0x20 on the following cycle -> that load still returns 9.
REQ-031 SHALL pass: two loads in flight with flush_en pulsed for one cycle -> no valid pulses. A load issued after the flush responds normally.
REQ-032 SHALL pass, with DMEM_MISALIGN_CHECK_EN defined: word load @0x6 -> mem_misalign pulse next cycle and no mem_load_valid. Asserting rst mid-load -> mem_load_valid=0 immediately and no stale response after release.
